// File: rtl/data_ram_arb_pkg.sv
// rtl/data_ram_arb_pkg.sv - shared types, widths and round-robin pick for the data RAM arbiter
package data_ram_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_OWN0, ARB_OWN1} arb_state_t;

    localparam int DRAM_AW = 8;
    localparam int DRAM_DW = 8;

    // Winner among the requesting ports; on a tie the port that did not own last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11) begin
            return ~last;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/data_ram_arb_mux.sv
// rtl/data_ram_arb_mux.sv - combinational owner-based selector of RAM address, write-enable and write data
//   sel_i                 owner port index
//   addr0_i / addr1_i     per-port address
//   we_i                  per-port write flag
//   wdata0_i / wdata1_i   per-port write data
//   addr_o, we_o, wdata_o selected port's fields
module data_ram_arb_mux #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          sel_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [1:0]    we_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [AW-1:0] addr_o,
    output logic          we_o,
    output logic [DW-1:0] wdata_o
);

    always_comb begin
        addr_o  = sel_i ? addr1_i  : addr0_i;
        we_o    = we_i[sel_i];
        wdata_o = sel_i ? wdata1_i : wdata0_i;
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// rtl/data_ram_arbiter.sv - round-robin, lockable arbiter sharing one single-port data RAM between two ports
//   CLK, RESET_N                clock, asynchronous active-low reset
//   req_i/we_i/lock_i[1:0]      per-port request, write flag, keep-ownership flag
//   addr0_i/addr1_i, wdata*_i   per-port address and write data
//   gnt_o[1:0]                  beat accepted this cycle
//   rvalid_o[1:0], rdata_o      registered read response
//   ram_addr_o/ram_we_o/ram_wdata_o, ram_rdata_i   RAM interface
//   Optional (DATA_RAM_ARB_STATS_EN): stat_beats0_o, stat_beats1_o, stat_forced_o
import data_ram_arb_pkg::*;

module data_ram_arbiter #(
    parameter int AW       = DRAM_AW,
    parameter int DW       = DRAM_DW,
    parameter int MAX_HOLD = 4
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic [1:0]    req_i,
    input  logic [1:0]    we_i,
    input  logic [1:0]    lock_i,
    input  logic [AW-1:0] addr0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [1:0]    gnt_o,
    output logic [1:0]    rvalid_o,
    output logic [DW-1:0] rdata_o,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_we_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i
`ifdef DATA_RAM_ARB_STATS_EN
    ,
    output logic [15:0]   stat_beats0_o,
    output logic [15:0]   stat_beats1_o,
    output logic [7:0]    stat_forced_o
`endif
);

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    arb_state_t    state_q, state_d;
    logic          rr_last_q, rr_last_d;
    logic [3:0]    hold_cnt_q, hold_cnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;

    logic          owner;
    logic          owning;
    logic          accept;
    logic [3:0]    hold_inc;
    logic          hold_hit;
    logic          forced;
    logic          rel;
    logic [AW-1:0] sel_addr;
    logic          sel_we;
    logic [DW-1:0] sel_wdata;

    assign owning = (state_q != ARB_IDLE);
    assign owner  = (state_q == ARB_OWN1);
    assign gnt_o  = {(state_q == ARB_OWN1) & req_i[1], (state_q == ARB_OWN0) & req_i[0]};
    assign accept = |gnt_o;

    data_ram_arb_mux #(.AW(AW), .DW(DW)) u_mux (
        .sel_i    (owner),
        .addr0_i  (addr0_i),
        .addr1_i  (addr1_i),
        .we_i     (we_i),
        .wdata0_i (wdata0_i),
        .wdata1_i (wdata1_i),
        .addr_o   (sel_addr),
        .we_o     (sel_we),
        .wdata_o  (sel_wdata)
    );

    // The RAM address is held between beats so the read port stays stable.
    assign ram_we_o    = accept & sel_we;
    assign ram_addr_o  = accept ? sel_addr : ram_addr_q;
    assign ram_wdata_o = owning ? sel_wdata : '0;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;

    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        hold_cnt_d = hold_cnt_q;
        rvalid_d   = 2'b00;
        rdata_d    = rdata_q;
        ram_addr_d = ram_addr_q;

        hold_inc = (hold_cnt_q >= MAX_HOLD_C) ? MAX_HOLD_C : hold_cnt_q + 4'd1;
        hold_hit = accept && (hold_inc == MAX_HOLD_C);
        // Forced: the hold bound ends ownership that the lock would otherwise keep.
        forced   = hold_hit && lock_i[owner];
        rel      = owning && ((accept && !lock_i[owner]) ||
                              (!req_i[owner] && !lock_i[owner]) ||
                              hold_hit);

        if (accept) begin
            ram_addr_d = sel_addr;
            hold_cnt_d = hold_inc;
            if (!sel_we) begin
                rdata_d         = ram_rdata_i;
                rvalid_d[owner] = 1'b1;
            end
        end

        case (state_q)
            ARB_IDLE: begin
                if (|req_i) begin
                    state_d = rr_pick(req_i, rr_last_q) ? ARB_OWN1 : ARB_OWN0;
                end
            end
            default: begin
                if (rel) begin
                    rr_last_d  = owner;
                    hold_cnt_d = 4'd0;
                    if (req_i[!owner]) begin
                        state_d = owner ? ARB_OWN0 : ARB_OWN1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= ARB_IDLE;
            rr_last_q  <= 1'b1;
            hold_cnt_q <= 4'd0;
            rvalid_q   <= 2'b00;
            rdata_q    <= '0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            hold_cnt_q <= hold_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
        end
    end

`ifdef DATA_RAM_ARB_STATS_EN
    logic [15:0] stat_beats0_q, stat_beats0_d;
    logic [15:0] stat_beats1_q, stat_beats1_d;
    logic [7:0]  stat_forced_q, stat_forced_d;

    always_comb begin
        stat_beats0_d = stat_beats0_q;
        stat_beats1_d = stat_beats1_q;
        stat_forced_d = stat_forced_q;
        if (gnt_o[0] && (stat_beats0_q != 16'hFFFF)) stat_beats0_d = stat_beats0_q + 16'd1;
        if (gnt_o[1] && (stat_beats1_q != 16'hFFFF)) stat_beats1_d = stat_beats1_q + 16'd1;
        if (forced && (stat_forced_q != 8'hFF))      stat_forced_d = stat_forced_q + 8'd1;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stat_beats0_q <= '0;
            stat_beats1_q <= '0;
            stat_forced_q <= '0;
        end else begin
            stat_beats0_q <= stat_beats0_d;
            stat_beats1_q <= stat_beats1_d;
            stat_forced_q <= stat_forced_d;
        end
    end

    assign stat_beats0_o = stat_beats0_q;
    assign stat_beats1_o = stat_beats1_q;
    assign stat_forced_o = stat_forced_q;
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// tb/tb_data_ram_arbiter.sv - scoreboard bench for data_ram_arbiter with a behavioural RAM and reference memory
module tb_data_ram_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [1:0] req, we, lock;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;
    logic       ram_we;
`ifdef DATA_RAM_ARB_STATS_EN
    logic [15:0] stat_beats0, stat_beats1;
    logic [7:0]  stat_forced;
`endif

    always #5 CLK = ~CLK;

    data_ram_arbiter #(.AW(8), .DW(8), .MAX_HOLD(4)) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .req_i       (req),
        .we_i        (we),
        .lock_i      (lock),
        .addr0_i     (addr0),
        .addr1_i     (addr1),
        .wdata0_i    (wdata0),
        .wdata1_i    (wdata1),
        .gnt_o       (gnt),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .ram_addr_o  (ram_addr),
        .ram_we_o    (ram_we),
        .ram_wdata_o (ram_wdata),
        .ram_rdata_i (ram_rdata)
`ifdef DATA_RAM_ARB_STATS_EN
        ,
        .stat_beats0_o (stat_beats0),
        .stat_beats1_o (stat_beats1),
        .stat_forced_o (stat_forced)
`endif
    );

    // Behavioural single-port RAM: synchronous write, combinational read.
    logic [7:0] mem [256];
    logic       fill;
    always @(posedge CLK) begin
        if (fill) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i ^ 8'h5C);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr];

    // Reference model: memory image in issue order and per-port expected read data.
    logic [7:0] ref_mem [256];
    logic [7:0] exp0 [$];
    logic [7:0] exp1 [$];
    bit         glog [$];
    int         gcyc [$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         n_beats0 = 0;
    int         n_beats1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every read response and logs grants.
    always @(negedge CLK) begin
        cyc++;
        if (RESET_N) begin
            if (gnt != 2'b00) begin
                glog.push_back(gnt[1]);
                gcyc.push_back(cyc);
            end
            if (gnt == 2'b00) check("we_without_gnt", 32'(ram_we), 32'd0);
            if (rvalid[0]) begin
                if (exp0.size() == 0) check("rvalid0_unexpected", 32'd1, 32'd0);
                else check("rdata_port0", 32'(rdata), 32'(exp0.pop_front()));
            end
            if (rvalid[1]) begin
                if (exp1.size() == 0) check("rvalid1_unexpected", 32'd1, 32'd0);
                else check("rdata_port1", 32'(rdata), 32'(exp1.pop_front()));
            end
        end
    end

    // One beat on port p: hold the request until granted, then drop it after the accepting edge.
    task automatic beat(input int p, input bit w, input logic [7:0] a, input logic [7:0] d,
                        input bit lk, output int waits);
        if (w) ref_mem[a] = d;
        else if (p == 0) exp0.push_back(ref_mem[a]);
        else exp1.push_back(ref_mem[a]);
        if (p == 0) begin addr0 = a; wdata0 = d; end
        else begin addr1 = a; wdata1 = d; end
        we[p]   = w;
        lock[p] = lk;
        req[p]  = 1'b1;
        waits   = 0;
        @(negedge CLK);
        while (!gnt[p] && waits < 200) begin
            waits++;
            @(negedge CLK);
        end
        if (!gnt[p]) check("grant_timeout", 32'(p), 32'hFFFF_FFFF);
        @(posedge CLK);
        #1;
        req[p]  = 1'b0;
        lock[p] = 1'b0;
        if (p == 0) n_beats0++; else n_beats1++;
    endtask

    function automatic logic [31:0] glog_bits();
        logic [31:0] v = 0;
        foreach (glog[i]) v = {v[30:0], glog[i]};
        return v;
    endfunction

    task automatic clear_log();
        glog.delete();
        gcyc.delete();
    endtask

    task automatic mem_compare(input string name);
        int errs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) errs++;
        check(name, 32'(errs), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, w1;
        RESET_N = 1'b0;
        fill = 1'b1;
        req = 0; we = 0; lock = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i ^ 8'h5C);
        @(posedge CLK);
        #1 fill = 1'b0;
        @(negedge CLK);
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_rdata", 32'(rdata), 32'd0);
        check("reset_ram_we", 32'(ram_we), 32'd0);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;

        // Tie from IDLE: port 0 first, then strict alternation with no bubble.
        clear_log();
        fork
            begin beat(0, 1, 8'h20, 8'h3C, 0, w0); beat(0, 0, 8'h20, 8'h00, 0, w0); end
            begin beat(1, 1, 8'h21, 8'hC3, 0, w1); beat(1, 0, 8'h21, 8'h00, 0, w1); end
        join
        @(negedge CLK);
        check("alt_count", 32'(glog.size()), 32'd4);
        check("alt_order", glog_bits(), 32'b0101);
        if (gcyc.size() == 4) check("alt_no_bubble", 32'(gcyc[3] - gcyc[0]), 32'd3);

        // Port 0 alone: write then read back, one-cycle grant latency from IDLE.
        @(posedge CLK); #1;
        beat(0, 1, 8'h10, 8'hA5, 0, w0);
        check("latency_write", 32'(w0), 32'd1);
        beat(0, 0, 8'h10, 8'h00, 0, w0);
        check("latency_read", 32'(w0), 32'd1);

        // Port 1 locked burst of six beats, port 0 waiting: forced release after beat 4.
        repeat (2) @(posedge CLK); #1;
        clear_log();
        fork
            begin
                for (int i = 0; i < 6; i++)
                    beat(1, 1, 8'(8'h50 + i), 8'(8'hE0 + i), (i < 5), w1);
            end
            begin
                repeat (2) @(posedge CLK); #1;
                beat(0, 1, 8'h40, 8'h77, 0, w0);
            end
        join
        @(negedge CLK);
        check("hold_count", 32'(glog.size()), 32'd7);
        check("hold_order", glog_bits(), 32'b1111011);

        // Address boundaries from both ports.
        @(posedge CLK); #1;
        beat(0, 1, 8'h3F, 8'h11, 0, w0);
        beat(1, 1, 8'hFF, 8'h22, 0, w1);
        beat(0, 1, 8'h00, 8'h33, 0, w0);
        beat(0, 0, 8'hFF, 8'h00, 0, w0);
        beat(1, 0, 8'hFF, 8'h00, 0, w1);
        beat(0, 0, 8'h00, 8'h00, 0, w0);
        beat(1, 0, 8'h00, 8'h00, 0, w1);
        beat(1, 0, 8'h3F, 8'h00, 0, w1);
        beat(0, 1, 8'h3F, 8'h44, 0, w0);
        beat(1, 0, 8'h3F, 8'h00, 0, w1);
        repeat (3) @(negedge CLK);
        mem_compare("mem_after_directed");
`ifdef DATA_RAM_ARB_STATS_EN
        check("stat_beats0", 32'(stat_beats0), 32'(n_beats0));
        check("stat_beats1", 32'(stat_beats1), 32'(n_beats1));
        check("stat_forced", 32'(stat_forced), 32'd1);
`endif

        // Reset mid-burst while a write beat is being presented.
        @(posedge CLK); #1;
        beat(0, 1, 8'h80, 8'hC1, 1, w0);
        beat(0, 0, 8'h80, 8'h00, 1, w0);
        addr0 = 8'h82; wdata0 = 8'h5A; we[0] = 1'b1; lock[0] = 1'b1; req[0] = 1'b1;
        @(negedge CLK);
        check("burst_gnt", 32'(gnt), 32'd1);
        check("burst_we", 32'(ram_we), 32'd1);
        #1 RESET_N = 1'b0;
        #1;
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        @(posedge CLK); #1;
        check("rst_mem_kept", 32'(mem[8'h82]), 32'(ref_mem[8'h82]));
        req = 0; lock = 0; we = 0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check("post_rst_rdata", 32'(rdata), 32'd0);
`ifdef DATA_RAM_ARB_STATS_EN
        check("post_rst_stats", 32'(stat_beats0) + 32'(stat_beats1) + 32'(stat_forced), 32'd0);
`endif

        // Randomized traffic; each port owns addresses of its own parity.
        @(posedge CLK); #1;
        fork
            begin
                int wa;
                for (int i = 0; i < 40; i++) begin
                    beat(0, 1'($urandom), {7'($urandom), 1'b0}, 8'($urandom),
                         1'($urandom), wa);
                    repeat ($urandom_range(0, 2)) @(posedge CLK);
                    #1;
                end
            end
            begin
                int wb;
                for (int i = 0; i < 40; i++) begin
                    beat(1, 1'($urandom), {7'($urandom), 1'b1}, 8'($urandom),
                         1'($urandom), wb);
                    repeat ($urandom_range(0, 2)) @(posedge CLK);
                    #1;
                end
            end
        join
        repeat (3) @(negedge CLK);
        check("exp0_drained", 32'(exp0.size()), 32'd0);
        check("exp1_drained", 32'(exp1.size()), 32'd0);
        mem_compare("mem_after_random");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
